// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared codes, state encoding and helpers for the iterative mul/div unit
package muldiv_sequencer_pkg;

    localparam logic [5:0] FUNC_MUL  = 6'b011000;
    localparam logic [5:0] FUNC_MULU = 6'b011001;
    localparam logic [5:0] FUNC_DIV  = 6'b011010;
    localparam logic [5:0] FUNC_DIVU = 6'b011011;
    localparam logic [4:0] SA_LO     = 5'b00010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // The four supported codes share the upper four bits 0110.
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == FUNC_MUL[5:2];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/response bundle between CPU control and the mul/div unit
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [4:0]       sa;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, func, sa, op_a, op_b, flush,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, func, sa, op_a, op_b, flush,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one combinational shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
    // Divide:   acc = {partial remainder, remaining dividend}, shifted left; the
    //           quotient bit is returned separately and merged into bit 0 by the caller.
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        trial  = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = trial[WIDTH-1:0] - operand_i;
        qbit_o = 1'b0;
        acc_o  = {sum, acc_i[WIDTH-1:1]};
        if (div_mode_i) begin
            qbit_o = (trial >= {1'b0, operand_i});
            acc_o  = {(qbit_o ? diff : trial[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle mul/muh/div/mod sequencer with fixed 34-cycle latency
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(STEPS + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic                 is_signed_q, is_signed_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 sa_lo_q, sa_lo_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 dz_q, dz_d;

    logic [2*WIDTH-1:0]   acc_step;
    logic                 qbit;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     a_abs;
    logic                 dz;
    logic                 sgn_start;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .div_mode_i (is_div_q),
        .acc_i      (acc_q),
        .operand_i  (opb_q),
        .acc_o      (acc_step),
        .qbit_o     (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            sa_lo_q     <= 1'b0;
            result_q    <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            sa_lo_q     <= sa_lo_d;
            result_q    <= result_d;
            dz_q        <= dz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        sa_lo_d     = sa_lo_q;
        result_d    = result_q;
        dz_d        = dz_q;
        sgn_start   = ~bus.func[0];
        a_abs       = (sgn_start && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
        prod        = (is_signed_q && (neg_a_q ^ neg_b_q)) ? (~acc_q + 1'b1) : acc_q;
        quo         = (is_signed_q && (neg_a_q ^ neg_b_q)) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                                           : acc_q[WIDTH-1:0];
        rem         = (is_signed_q && neg_a_q) ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                               : acc_q[2*WIDTH-1:WIDTH];
        dz          = is_div_q && (opb_q == '0);
        if (dz) begin
            quo = '1;
            rem = opa_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && is_muldiv(bus.func)) begin
                    is_div_d    = bus.func[1];
                    is_signed_d = sgn_start;
                    sa_lo_d     = (bus.sa == SA_LO);
                    neg_a_d     = sgn_start && bus.op_a[WIDTH-1];
                    neg_b_d     = sgn_start && bus.op_b[WIDTH-1];
                    opa_d       = bus.op_a;
                    opb_d       = (sgn_start && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
                    acc_d       = {{WIDTH{1'b0}}, a_abs};
                    cnt_d       = '0;
                    state_d     = ST_RUN;
                end
            end
            // One settle cycle after the last step keeps the latency at 34 edges.
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(STEPS)) begin
                    state_d = ST_FIX;
                end else begin
                    acc_d = acc_step | {{(2*WIDTH-1){1'b0}}, qbit};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) result_d = sa_lo_q ? quo : rem;
                    else          result_d = sa_lo_q ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                    dz_d    = dz;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.result      = result_q;
    assign bus.div_by_zero = dz_q && (state_q == ST_DONE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed-vector bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [4:0] s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_dz);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        bus.sa    = s;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd34);
        check({tag, " result"}, 64'(bus.result), 64'(exp_res));
        check({tag, " dz"}, 64'(bus.div_by_zero), 64'(exp_dz));
        @(negedge clk);
        check({tag, " after"}, {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    endtask

    initial begin
        int dones;
        int busy_seen;
        logic [31:0] res_at_done;
        logic        dz_at_done;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.func    = 6'd0;
        bus.sa      = 5'd0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.flush   = 1'b0;

        #12;
        check("reset outs", {29'd0, bus.busy, bus.done, bus.div_by_zero, bus.result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("muhu max",  FUNC_MULU, 5'b00011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulu max",  FUNC_MULU, 5'b00010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op("mul -7*3",  FUNC_MUL,  5'b00010, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFEB, 1'b0);
        run_op("muh -7*3",  FUNC_MUL,  5'b00011, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 1'b0);
        run_op("div -7/2",  FUNC_DIV,  5'b00010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("mod -7/2",  FUNC_DIV,  5'b00011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("div ovf",   FUNC_DIV,  5'b00010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("mod ovf",   FUNC_DIV,  5'b00011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("divu /0",   FUNC_DIVU, 5'b00010, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1'b1);
        run_op("modu /0",   FUNC_DIVU, 5'b00011, 32'h12345678, 32'd0,        32'h12345678, 1'b1);
        run_op("mod /0",    FUNC_DIV,  5'b00011, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1);
        run_op("div /0",    FUNC_DIV,  5'b00010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1);
        run_op("mulu x0",   FUNC_MULU, 5'b00010, 32'd5,        32'd0,        32'd0,        1'b0);
        run_op("mod 7/-2",  FUNC_DIV,  5'b00011, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0);

        // start pulsed in the fifth busy cycle must be dropped
        @(negedge clk);
        bus.start = 1'b1; bus.func = FUNC_MULU; bus.sa = SA_LO; bus.op_a = 32'd6; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.func = FUNC_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; res_at_done = '0; dz_at_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                res_at_done = bus.result;
                dz_at_done  = bus.div_by_zero;
            end
            @(negedge clk);
        end
        check("busy start dones", 64'(dones), 64'd1);
        check("busy start result", 64'(res_at_done), 64'h2A);
        check("busy start dz", 64'(dz_at_done), 64'd0);

        // unsupported func is ignored
        bus.start = 1'b1; bus.func = 6'b100000;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busy_seen++;
            @(negedge clk);
        end
        check("bad func busy", 64'(busy_seen), 64'd0);
        check("bad func done", 64'(dones), 64'd0);

        // flush in RUN cycle 10
        bus.start = 1'b1; bus.func = FUNC_MULU; bus.sa = SA_LO; bus.op_a = 32'd3; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("flush done", 64'(dones), 64'd0);
        check("flush result", 64'(bus.result), 64'h2A);

        // asynchronous reset between edges mid-RUN
        bus.start = 1'b1; bus.func = FUNC_DIVU; bus.sa = SA_LO; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst busy", 64'(bus.busy), 64'd0);
        check("arst state", 64'(dut.state_q), 64'(ST_IDLE));
        check("arst result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu 100/7", FUNC_DIVU, 5'b00010, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("modu 100/7", FUNC_DIVU, 5'b00011, 32'd100, 32'd7, 32'd2,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative multiply/divide unit that takes the mul/muh/mulu/muhu/div/mod/divu/modu group (func 011000–011011) off the single-cycle ALU critical path.
- Accepts one operation per request, runs a 32-step shift-add / shift-subtract loop, then pulses done with the 32-bit result.
- Drives busy so the CPU control unit can stall the PC and register write-back while the operation runs.

Parameters:
- WIDTH, 32, operand and result width.
- STEPS, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- func  input  6  operation group: 011000 mul/muh, 011001 mulu/muhu, 011010 div/mod, 011011 divu/modu.
- sa  input  5  selects the half: 00010 = low product / quotient; any other value = high product / remainder.
- op_a  input  WIDTH  multiplicand / dividend (rs value).
- op_b  input  WIDTH  multiplier / divisor (rt value).
- flush  input  1  synchronous abort of the operation in flight.
- busy  output  1  high from the cycle after an accepted start until done is asserted, inclusive.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  WIDTH  selected result; holds its value until the next done.
- div_by_zero  output  1  valid with done; 1 when a div/mod operation had op_b = 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, div_by_zero=0; counter, accumulators and captured operands cleared. Reset during RUN discards the operation and produces no done.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 with func in 011000..011011: capture func, sa, op_a, op_b and sign flags; for signed ops, load |op_a| and |op_b|.
  - Set cnt=0 and go to RUN.
  - start with any other func is ignored: no busy, no done.
- RUN: one iteration per cycle; after the step with cnt==STEPS-1, go to FIX.
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
- FIX (1 cycle), signed sign correction:
  - Product: negate the 64-bit product if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Latch the half selected by sa into result.
- DONE (1 cycle): done=1, busy=1, then return to IDLE.
- Latency: start accepted at edge T0 -> done high in the cycle following edge T0+34. Fixed for every operation, including divide-by-zero.
- Start during busy: ignored and not queued.
- Flush: in RUN or FIX, return to IDLE at the next edge with no done; result keeps its previous value. Flush in IDLE or DONE has no effect; the DONE pulse still completes.
- Divide by zero (op_b==0, func 011010/011011):
  - quotient = 0xFFFFFFFF; remainder = original op_a with no sign fix; div_by_zero=1 in the done cycle.
  - Signed and unsigned are treated identically.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; no flag.
- Width rules:
  - |x| is computed as a 32-bit unsigned value, so |0x80000000| = 0x80000000.
  - Product accumulator is 64 bits; divide partial remainder is 33 bits.
- div_by_zero is 0 for multiply operations and outside the done cycle.

Decomposition:
- Shared package:
  - func codes FUNC_MUL=6'b011000, FUNC_MULU=6'b011001, FUNC_DIV=6'b011010, FUNC_DIVU=6'b011011.
  - SA_LO=5'b00010.
  - State encoding IDLE/RUN/FIX/DONE.
- One combinational sub-module, muldiv_iter: one shift-add or shift-subtract step (inputs: mode, accumulator, divisor/multiplicand; outputs: next accumulator, quotient bit).

Test Plan:
- mulu: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, sa=00011 (muhu) -> done 34 cycles after start, result=0xFFFFFFFE; rerun with sa=00010 -> result=0x00000001.
- mul signed: op_a=0xFFFFFFF9 (-7), op_b=3, sa=00010 -> result=0xFFFFFFEB; with sa=00011 -> 0xFFFFFFFF.
- div/mod signed: -7/2 with sa=00010 -> 0xFFFFFFFD; with sa=00011 -> 0xFFFFFFFF. Then 0x80000000/0xFFFFFFFF -> quotient 0x80000000, div_by_zero=0.
- divu by zero: op_a=0x12345678, op_b=0 -> quotient 0xFFFFFFFF, modu gives 0x12345678, div_by_zero=1 for exactly one cycle.
- Control: start pulsed at cycle 5 of busy -> ignored, one done only; func=100000 with start -> busy stays 0; flush at RUN cycle 10 -> no done, result unchanged.
- Asynchronous rst asserted mid-RUN, between clock edges -> busy=0 and state=IDLE immediately; a new operation after release completes correctly.
